// File: rtl/universal_shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// Holds the mode codes, FSM state encoding and the burst-amount clamp helper.
package shiftreg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SR    = 3'b001,
    MODE_SL    = 3'b010,
    MODE_RR    = 3'b011,
    MODE_RL    = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Burst amounts beyond the register width are limited to the width.
  function automatic int unsigned clamp_amount(input int unsigned amount,
                                               input int unsigned n);
    return (amount > n) ? n : amount;
  endfunction

  // Only the four shift/rotate codes can drive a burst.
  function automatic logic is_shift_mode(input mode_e m);
    return (m == MODE_SR) || (m == MODE_SL) || (m == MODE_RR) || (m == MODE_RL);
  endfunction

endpackage

// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg.
// master: drives control/data (en, mode, sin_r, sin_l, d, start, amount),
//         observes q, sout_r, sout_l, busy, done.
// slave : the shift register side.
interface universal_shift_reg_if #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
);
  logic          en;
  logic [2:0]    mode;
  logic          sin_r;
  logic          sin_l;
  logic [N-1:0]  d;
  logic          start;
  logic [CW-1:0] amount;
  logic [N-1:0]  q;
  logic          sout_r;
  logic          sout_l;
  logic          busy;
  logic          done;

  modport master (
    output en, mode, sin_r, sin_l, d, start, amount,
    input  q, sout_r, sout_l, busy, done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, d, start, amount,
    output q, sout_r, sout_l, busy, done
  );
endinterface

// File: rtl/universal_shift_reg_shift_step.sv
// One step of the shift register datapath (purely combinational).
// Ports: q_i current contents, mode_i operation, sin_r_i/sin_l_i serial
//        inputs, d_i parallel load data, q_o next contents.
module shift_step
  import shiftreg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] q_i,
  input  mode_e        mode_i,
  input  logic         sin_r_i,
  input  logic         sin_l_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  always_comb begin
    q_o = q_i;
    case (mode_i)
      MODE_SR:    q_o = {sin_r_i, q_i[N-1:1]};
      MODE_SL:    q_o = {q_i[N-2:0], sin_l_i};
      MODE_RR:    q_o = {q_i[0], q_i[N-1:1]};
      MODE_RL:    q_o = {q_i[N-2:0], q_i[N-1]};
      MODE_LOAD:  q_o = d_i;
      MODE_CLEAR: q_o = '0;
      default:    q_o = q_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Parametrised N-bit universal shift register with burst shifting.
// Ports: clock, reset (sync, active-high); bus (slave modport) carrying
//        en, mode, sin_r, sin_l, d, start, amount in and q, sout_r, sout_l,
//        busy, done out.
module universal_shift_reg
  import shiftreg_pkg::*;
#(
  parameter int           N           = 4,
  parameter logic [N-1:0] RESET_VALUE = N'(4'b0010),
  parameter int           CW          = $clog2(N + 1)
) (
  input logic                 clock,
  input logic                 reset,
  universal_shift_reg_if.slave bus
);

  state_e        state_q, state_d;
  mode_e         dir_q, dir_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [N-1:0]  q_q, q_d;
  logic          done_q, done_d;

  mode_e         step_mode;
  logic [N-1:0]  step_q;
  logic [CW-1:0] amount_clamped;

  assign amount_clamped = CW'(clamp_amount(32'(bus.amount), N));

  // The single step unit is shared: in BURST it follows the latched
  // direction, otherwise the live mode input.
  shift_step #(.N(N)) u_step (
    .q_i     (q_q),
    .mode_i  (step_mode),
    .sin_r_i (bus.sin_r),
    .sin_l_i (bus.sin_l),
    .d_i     (bus.d),
    .q_o     (step_q)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    q_d       = q_q;
    done_d    = 1'b0;
    step_mode = mode_e'(bus.mode);

    case (state_q)
      BURST: begin
        step_mode = dir_q;
        if (bus.en) begin
          q_d   = step_q;
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        if (bus.start) begin
          // Start takes precedence over the single-cycle op; q is untouched.
          dir_d = mode_e'(bus.mode);
          rem_d = amount_clamped;
          if (is_shift_mode(mode_e'(bus.mode)) && (amount_clamped != '0)) begin
            state_d = BURST;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.en) begin
          q_d = step_q;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= MODE_HOLD;
      rem_q   <= '0;
      q_q     <= RESET_VALUE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.sout_r = q_q[0];
  assign bus.sout_l = q_q[N-1];
  assign bus.busy   = (state_q == BURST);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

  localparam int N  = 4;
  localparam int CW = 3;

  logic clock;
  logic reset;

  int checks;
  int errors;

  universal_shift_reg_if #(.N(N), .CW(CW)) bus ();

  universal_shift_reg #(.N(N), .RESET_VALUE(4'b0010), .CW(CW)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         en;
    logic [2:0]   mode;
    logic         sin_r;
    logic         sin_l;
    logic [N-1:0] d;
    logic [N-1:0] exp_q;
    logic         exp_sr;
    logic         exp_sl;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string name, input logic [N-1:0] q,
                             input logic busy, input logic done);
    check({name, ".q"}, 32'(bus.q), 32'(q));
    check({name, ".busy"}, 32'(bus.busy), 32'(busy));
    check({name, ".done"}, 32'(bus.done), 32'(done));
  endtask

  initial begin
    int steps;
    bit got_done;

    checks = 0;
    errors = 0;

    //          en mode    sr  sl  d        q        sout_r sout_l
    vecs[0]  = '{1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b1001, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b1100, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 3'b101, 1'b0, 1'b0, 4'b1011, 4'b1011, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 3'b100, 1'b0, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 3'b011, 1'b0, 1'b0, 4'b0000, 4'b1011, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 3'b110, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'b101, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'b010, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 3'b010, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 3'b111, 1'b1, 1'b1, 4'b1111, 4'b0010, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 3'b000, 1'b1, 1'b1, 4'b1111, 4'b0010, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'b011, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};

    reset      = 1'b1;
    bus.en     = 1'b0;
    bus.mode   = 3'b000;
    bus.sin_r  = 1'b0;
    bus.sin_l  = 1'b0;
    bus.d      = '0;
    bus.start  = 1'b0;
    bus.amount = '0;
    tick();
    tick();
    check_state("reset", 4'b0010, 1'b0, 1'b0);
    check("reset.sout_r", 32'(bus.sout_r), 32'd0);
    reset = 1'b0;

    // Single-cycle operations
    for (int i = 0; i < 13; i++) begin
      bus.en    = vecs[i].en;
      bus.mode  = vecs[i].mode;
      bus.sin_r = vecs[i].sin_r;
      bus.sin_l = vecs[i].sin_l;
      bus.d     = vecs[i].d;
      tick();
      check($sformatf("vec%0d", i), 32'(bus.q), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d.sout_r", i), 32'(bus.sout_r), 32'(vecs[i].exp_sr));
      check($sformatf("vec%0d.sout_l", i), 32'(bus.sout_l), 32'(vecs[i].exp_sl));
      check($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'd0);
    end

    // Burst SL by 3 from 1011; mode/d changes while busy must be ignored
    bus.en = 1'b1; bus.mode = 3'b101; bus.d = 4'b1011;
    tick();
    bus.mode = 3'b010; bus.sin_l = 1'b0; bus.amount = 3'd3; bus.start = 1'b1;
    tick();
    check_state("sl3.t0", 4'b1011, 1'b1, 1'b0);
    bus.start = 1'b0; bus.mode = 3'b101; bus.d = 4'b1111;
    tick();
    check_state("sl3.s1", 4'b0110, 1'b1, 1'b0);
    tick();
    check_state("sl3.s2", 4'b1100, 1'b1, 1'b0);
    tick();
    check_state("sl3.s3", 4'b1000, 1'b0, 1'b1);
    bus.en = 1'b0;
    tick();
    check_state("sl3.after", 4'b1000, 1'b0, 1'b0);

    // Burst SR by 2 with a two-cycle stall between steps
    bus.mode = 3'b001; bus.sin_r = 1'b1; bus.amount = 3'd2; bus.start = 1'b1;
    tick();
    check_state("sr2.t0", 4'b1000, 1'b1, 1'b0);
    bus.start = 1'b0; bus.en = 1'b1;
    tick();
    check_state("sr2.s1", 4'b1100, 1'b1, 1'b0);
    bus.en = 1'b0;
    tick();
    check_state("sr2.stall1", 4'b1100, 1'b1, 1'b0);
    tick();
    check_state("sr2.stall2", 4'b1100, 1'b1, 1'b0);
    bus.en = 1'b1;
    tick();
    check_state("sr2.s2", 4'b1110, 1'b0, 1'b1);

    // amount=0 with en low: immediate done, q unchanged
    bus.en = 1'b0; bus.mode = 3'b001; bus.amount = 3'd0; bus.start = 1'b1;
    tick();
    check_state("amt0", 4'b1110, 1'b0, 1'b1);
    // new start accepted while done is high
    bus.en = 1'b1; bus.mode = 3'b011; bus.amount = 3'd1;
    tick();
    check_state("rr1.t0", 4'b1110, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick();
    check_state("rr1.s1", 4'b0111, 1'b0, 1'b1);
    // non-shift mode start: done only, no load
    bus.mode = 3'b101; bus.d = 4'b0000; bus.amount = 3'd2; bus.start = 1'b1;
    tick();
    check_state("load_start", 4'b0111, 1'b0, 1'b1);
    bus.start = 1'b0; bus.en = 1'b0;
    tick();
    check_state("load_start.after", 4'b0111, 1'b0, 1'b0);

    // RL burst with amount 7 clamps to 4 and restores q; stray start ignored
    bus.en = 1'b1; bus.mode = 3'b100; bus.amount = 3'd7; bus.start = 1'b1;
    tick();
    check_state("rl7.t0", 4'b0111, 1'b1, 1'b0);
    bus.start = 1'b0;
    steps = 0;
    got_done = 1'b0;
    for (int k = 0; k < 10 && !got_done; k++) begin
      if (k == 1) begin
        bus.start = 1'b1; bus.mode = 3'b001; bus.amount = 3'd1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      steps++;
      if (bus.done) got_done = 1'b1;
    end
    bus.start = 1'b0;
    check("rl7.done_seen", 32'(got_done), 32'd1);
    check("rl7.steps", 32'(steps), 32'd4);
    check_state("rl7.end", 4'b0111, 1'b0, 1'b1);

    // Reset during the second step of a 4-step burst
    bus.en = 1'b1; bus.mode = 3'b010; bus.sin_l = 1'b0; bus.amount = 3'd4;
    bus.start = 1'b1;
    tick();
    check_state("abort.t0", 4'b0111, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick();
    check_state("abort.s1", 4'b1110, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    check_state("abort.reset", 4'b0010, 1'b0, 1'b0);
    reset = 1'b0; bus.en = 1'b0;
    tick();
    check_state("abort.after", 4'b0010, 1'b0, 1'b0);
    tick();
    check_state("abort.after2", 4'b0010, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
